fir_sample_feeder: RTL
======================

# fir_sample_feeder

Transmit-side driver for the FIR filter's sample input: accepts samples from an upstream producer over a valid/ready handshake, buffers them, and emits them on the filter's `data` / `data_ready` interface at a fixed sample period. It replaces testbench-style delay pacing with synthesizable cycle-accurate pacing. It sits directly in front of `firfilter`, so the filter sees exactly one single-cycle `data_ready` strobe per sample slot.

## Interface
- `DATA_SIZE`, 9: sample width, signed two's complement; must match the filter's `DATA_SIZE`.
- `DEPTH`, 16: FIFO depth in samples; power of two, ≥2.
- `PERIOD`, 10: clock cycles per sample slot; ≥2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  DATA_SIZE  signed sample from producer.
- `in_valid`  in  1  producer offers `in_data`.
- `in_ready`  out  1  FIFO can accept; equals not-full.
- `enable`  in  1  run sample pacing; low = paused.
- `data`  out  DATA_SIZE  signed sample to filter; registered.
- `data_ready`  out  1  one-cycle strobe marking a new `data` value; registered.
- `underrun`  out  1  one-cycle pulse: slot arrived with FIFO empty.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Push: on a rising edge with `in_valid && in_ready`, `in_data` is written. Without `in_ready`, nothing is written and the producer must hold.
- Period counter `cnt`, 0..PERIOD-1:
  - While `enable`=0, `cnt` is held at 0.
  - While `enable`=1, `cnt` increments each cycle and wraps from PERIOD-1 to 0.
  - A slot occurs on the edge where `cnt`==PERIOD-1 and `enable`=1.
- At a slot, FIFO non-empty: pop the head into `data` and set `data_ready`=1 for exactly one cycle.
- At a slot, FIFO empty: `underrun`=1 for one cycle, `data_ready` stays 0, and `data` holds its last value.
- `data` holds between strobes. It changes only on a strobe edge or on reset.
- FSM states:
  - IDLE: `enable`=0.
  - COUNT: `enable`=1, `cnt` < PERIOD-1.
  - SLOT: the single cycle after the slot edge, in which `data_ready` or `underrun` is high.
  - Transitions: IDLE→COUNT when `enable` is sampled 1. COUNT→SLOT on the slot edge. SLOT→COUNT, or SLOT→IDLE if `enable` is 0. Any state→IDLE when `enable`=0.
- Boundary conditions:
  - Push and pop on the same edge: both occur, and `level` is unchanged.
  - Full: `in_ready`=0. A pop on that edge does not admit a push in the same cycle; `in_ready` rises the cycle after the pop.
  - Empty FIFO with a push on the slot edge: the new sample is not popped at this slot. The result is `underrun`, and the sample goes out at the next slot.
  - `enable` dropped mid-period: `cnt` clears, and FIFO contents and `data` are retained. Re-enabling restarts a full PERIOD.
  - FIFO pointers wrap modulo DEPTH. `level` distinguishes full (DEPTH) from empty (0).
  - Reset mid-operation: FIFO is emptied (contents discarded) and all outputs return to reset values immediately (async assert). Release is synchronous to the next `clk` edge.

## Timing
- Reset values: `data`=0, `data_ready`=0, `underrun`=0, `level`=0, `cnt`=0, `in_ready`=1.
- First slot comes PERIOD rising edges after the first edge at which `enable` is sampled 1. Successive strobes are exactly PERIOD cycles apart while the FIFO is non-empty.
- Push-to-poppable latency is 1 cycle: a sample written at edge t can be popped at a slot edge ≥ t+1.
- `data_ready`, `underrun` and `data` are registered outputs with no combinational path from inputs.
- `in_ready` is derived from registered `level` only.

## Structure
- Shared package `fir_pkg`:
  - default `DATA_SIZE`
  - FSM state enum (IDLE, COUNT, SLOT)
  - width helper for `cnt` and `level`
- Sub-module `sync_fifo`: DATA_SIZE×DEPTH, push/pop, full/empty/level, async active-low reset.
- Pacing counter, FSM and output registers live in `fir_sample_feeder`.

## Test plan
- Reset/idle: assert `rst_n`=0 mid-run with 3 samples queued → outputs 0 and `level`=0 immediately; after release, `in_ready`=1 and no strobes while `enable`=0.
- Nominal pacing: PERIOD=10, push 0x10, 0x15, 0x20, 0x25, then `enable`=1 → strobes at edges 10, 20, 30, 40 with `data` = 0x10, 0x15, 0x20, 0x25; each `data_ready` lasts 1 cycle and `data` holds between strobes.
- Underrun: enable with an empty FIFO → `underrun` pulse at edge 10 with `data_ready`=0 and `data` held; push 0x30 at edge 10 → 0x30 is emitted at edge 20.
- Full/backpressure: DEPTH=16, enable=0, push 17 samples → `in_ready`=0 after the 16th and the 17th is held by the producer; `level`=16; after enabling, the first pop raises `in_ready` one cycle later.
- Enable pause: drop `enable` at `cnt`=6 and re-raise 5 cycles later → next strobe exactly 10 cycles after the re-raise; FIFO order preserved.
- Signed/wrap: push -256 (0x100), 255 (0x0FF), then 20 more samples across the pointer wrap → emitted bit-exact and in order.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample feeder slice.
//   DEFAULT_DATA_SIZE : default sample width, matches the filter's DATA_SIZE
//   state_t           : pacing FSM state (IDLE / COUNT / SLOT)
//   width_of()        : bits needed to hold the values 0..max_value
package fir_pkg;

  localparam int DEFAULT_DATA_SIZE = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SLOT  = 2'd2
  } state_t;

  function automatic int width_of(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, DATA_SIZE x DEPTH (DEPTH a power of two).
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata : write request and data; ignored while full
//   pop         : read request; ignored while empty
//   rdata       : current head (valid while not empty)
//   full, empty : status, both derived from the registered level
//   level       : occupancy 0..DEPTH
module sync_fifo
  import fir_pkg::*;
#(
  parameter  int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter  int DEPTH     = 16,
  localparam int LW        = width_of(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 full,
  output logic                 empty,
  output logic [LW-1:0]        level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  // Status comes from the level register alone, so a pop on a full edge
  // cannot admit a push in the same cycle.
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array has no reset; occupancy is tracked by the
  // pointers and level, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Paces buffered samples onto the FIR filter input, one slot every PERIOD
// cycles while enabled.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data, in_valid   : producer sample and offer
//   in_ready            : FIFO not full (from registered level only)
//   enable              : run pacing; low holds the period counter at 0
//   data, data_ready    : registered sample and its one-cycle strobe
//   underrun            : one-cycle pulse when a slot finds the FIFO empty
//   level               : FIFO occupancy
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter  int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter  int DEPTH     = 16,
  parameter  int PERIOD    = 10,
  localparam int LW        = width_of(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [DATA_SIZE-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        enable,
  output logic signed [DATA_SIZE-1:0] data,
  output logic                        data_ready,
  output logic                        underrun,
  output logic [LW-1:0]               level
);

  localparam int            CW   = width_of(PERIOD - 1);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cnt;
  logic                 slot_edge;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_SIZE-1:0] head;

  assign in_ready = !fifo_full;

  sync_fifo #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Period counter: cleared while paused so re-enabling starts a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (!enable)       cnt <= '0;
    else if (cnt == LAST)   cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = COUNT;
        COUNT:   if (cnt == LAST) state_nxt = SLOT;
        SLOT:    state_nxt = COUNT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The last count of a period is only reachable in COUNT while enabled.
  always_comb begin
    slot_edge = 1'b0;
    pop       = 1'b0;
    if (state == COUNT && enable && cnt == LAST) begin
      slot_edge = 1'b1;
      pop       = !fifo_empty;
    end
  end

  // Emptiness is sampled before the edge, so a sample pushed on the slot
  // edge itself waits for the next slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      data_ready <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      data_ready <= pop;
      underrun   <= slot_edge && fifo_empty;
      if (pop) data <= head;
    end
  end

endmodule
